// File: rtl/ife_commit_unit_if.sv
// Bundle of dispatch, completion and commit signals around the IFE commit unit.
// The master side (dispatch stage / bench) drives dispatch and completion
// traffic plus commit_ready; the slave side (the commit unit) returns the
// commit record and the slot status.
interface ife_commit_unit_if #(
    parameter int BLOCK_ID_WIDTH = 8,
    parameter int NUM_CORES      = 4
);
    logic [BLOCK_ID_WIDTH-1:0] disp_block_id;
    logic                      disp_valid_parallel;
    logic [NUM_CORES-1:0]      disp_core;
    logic                      disp_valid_serial;
    logic [NUM_CORES-1:0]      core_done;
    logic                      serial_done;
    logic                      commit_ready;
    logic                      commit_valid;
    logic [BLOCK_ID_WIDTH-1:0] commit_block_id;
    logic                      commit_serial;
    logic [NUM_CORES-1:0]      core_idle_mask;
    logic                      serial_idle;
    logic                      err;

    modport master (
        output disp_block_id, disp_valid_parallel, disp_core, disp_valid_serial,
        output core_done, serial_done, commit_ready,
        input  commit_valid, commit_block_id, commit_serial,
        input  core_idle_mask, serial_idle, err
    );

    modport slave (
        input  disp_block_id, disp_valid_parallel, disp_core, disp_valid_serial,
        input  core_done, serial_done, commit_ready,
        output commit_valid, commit_block_id, commit_serial,
        output core_idle_mask, serial_idle, err
    );
endinterface

// File: rtl/ife_commit_unit.sv
// In-order retirement stage for IFE blocks. Each core owns one tracking slot
// and the serial path owns one more (the highest slot index). Finished blocks
// wait in their slot until their ID equals the expected ID, then move into a
// single valid/ready commit register. Protocol violations raise a sticky err.
module ife_commit_unit #(
    parameter int BLOCK_ID_WIDTH = 8,
    parameter int NUM_CORES      = 4
) (
    input  logic               clk,
    input  logic               rst,
    ife_commit_unit_if.slave   bus
);
    localparam int NUM_SLOTS   = NUM_CORES + 1;
    localparam int SERIAL_SLOT = NUM_CORES;
    localparam int SEL_WIDTH   = $clog2(NUM_SLOTS);

    // Slot state and commit record
    logic [NUM_SLOTS-1:0]      r_busy;
    logic [NUM_SLOTS-1:0]      r_done;
    logic [BLOCK_ID_WIDTH-1:0] r_id [NUM_SLOTS];
    logic [BLOCK_ID_WIDTH-1:0] r_expectedId;
    logic                      r_commitValid;
    logic [BLOCK_ID_WIDTH-1:0] r_commitBlockId;
    logic                      r_commitSerial;
    logic                      r_err;

    // Dispatch decode
    logic                      w_coreOneHot;
    logic                      w_coreTargetBusy;
    logic                      w_parAccept;
    logic                      w_serAccept;
    logic                      w_dispErr;
    logic [NUM_SLOTS-1:0]      w_dispMask;

    // Completion decode
    logic [NUM_SLOTS-1:0]      w_doneVec;
    logic [NUM_SLOTS-1:0]      w_doneSet;
    logic                      w_doneErr;

    // Selection and load
    logic                      w_match;
    logic                      w_dupErr;
    logic [SEL_WIDTH-1:0]      w_sel;
    logic                      w_load;
    logic [NUM_SLOTS-1:0]      w_clearMask;

    // A dispatch is taken only when exactly one path is requested, the core
    // select names a single core, and the target slot is free; a slot freed
    // by a load on this same edge still counts as busy here.
    assign w_coreOneHot     = $onehot(bus.disp_core);
    assign w_coreTargetBusy = |(bus.disp_core & r_busy[NUM_CORES-1:0]);
    assign w_parAccept      = bus.disp_valid_parallel & ~bus.disp_valid_serial &
                              w_coreOneHot & ~w_coreTargetBusy;
    assign w_serAccept      = bus.disp_valid_serial & ~bus.disp_valid_parallel &
                              ~r_busy[SERIAL_SLOT];
    assign w_dispErr        = (bus.disp_valid_parallel | bus.disp_valid_serial) &
                              ~(w_parAccept | w_serAccept);
    assign w_dispMask       = w_parAccept ? {1'b0, bus.disp_core} :
                              w_serAccept ? {1'b1, {NUM_CORES{1'b0}}} :
                                            {NUM_SLOTS{1'b0}};

    // Completions only matter for busy slots that have not finished yet;
    // a repeat done is harmless, a done on an empty slot is a protocol error.
    assign w_doneVec = {bus.serial_done, bus.core_done};
    assign w_doneSet = w_doneVec & r_busy & ~r_done;
    assign w_doneErr = |(w_doneVec & ~r_busy);

    // Find the lowest finished slot holding the expected ID; any further hit
    // means two in-flight blocks share an ID.
    always_comb begin
        w_match  = 1'b0;
        w_dupErr = 1'b0;
        w_sel    = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (r_busy[i] && r_done[i] && (r_id[i] == r_expectedId)) begin
                if (w_match) begin
                    w_dupErr = 1'b1;
                end else begin
                    w_match = 1'b1;
                    w_sel   = SEL_WIDTH'(i);
                end
            end
        end
    end

    assign w_load      = w_match & (~r_commitValid | bus.commit_ready);
    assign w_clearMask = w_load ? (NUM_SLOTS'(1) << w_sel) : {NUM_SLOTS{1'b0}};

    // Slot bookkeeping: dispatch fills a slot, done marks it, a load empties it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
            r_done <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_id[i] <= '0;
            end
        end else begin
            r_busy <= (r_busy | w_dispMask) & ~w_clearMask;
            r_done <= (r_done | w_doneSet) & ~w_clearMask & ~w_dispMask;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (w_dispMask[i]) begin
                    r_id[i] <= bus.disp_block_id;
                end
            end
        end
    end

    // Commit register: load a new record when free or being drained, drop
    // valid after a handshake with nothing behind it, otherwise hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_commitValid   <= 1'b0;
            r_commitBlockId <= '0;
            r_commitSerial  <= 1'b0;
            r_expectedId    <= '0;
        end else if (w_load) begin
            r_commitValid   <= 1'b1;
            r_commitBlockId <= r_id[w_sel];
            r_commitSerial  <= (w_sel == SEL_WIDTH'(SERIAL_SLOT));
            r_expectedId    <= r_expectedId + BLOCK_ID_WIDTH'(1);
        end else if (r_commitValid && bus.commit_ready) begin
            r_commitValid   <= 1'b0;
        end
    end

    // Sticky protocol error, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_dispErr || w_doneErr || w_dupErr) begin
            r_err <= 1'b1;
        end
    end

    assign bus.commit_valid    = r_commitValid;
    assign bus.commit_block_id = r_commitBlockId;
    assign bus.commit_serial   = r_commitSerial;
    assign bus.core_idle_mask  = ~r_busy[NUM_CORES-1:0];
    assign bus.serial_idle     = ~r_busy[SERIAL_SLOT];
    assign bus.err             = r_err;
endmodule

// File: tb/tb_ife_commit_unit.sv
// Bench for ife_commit_unit: directed scenarios followed by a randomized run,
// all compared every cycle against a slot-table model of the retirement rules.
module tb_ife_commit_unit;
    localparam int W  = 8;
    localparam int NC = 4;
    localparam int NS = NC + 1;
    localparam int ID_MOD = 1 << W;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ife_commit_unit_if #(.BLOCK_ID_WIDTH(W), .NUM_CORES(NC)) bus ();

    ife_commit_unit #(.BLOCK_ID_WIDTH(W), .NUM_CORES(NC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: one table entry per slot (serial slot last), the next
    // ID allowed to retire, and the record currently offered downstream.
    bit mBusy [NS];
    bit mDone [NS];
    int mId   [NS];
    int mExp;
    bit mCv;
    int mCid;
    bit mCs;
    bit mErr;

    int acceptCount;
    int nextId;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < NS; i++) begin
            mBusy[i] = 1'b0;
            mDone[i] = 1'b0;
            mId[i]   = 0;
        end
        mExp = 0;
        mCv  = 1'b0;
        mCid = 0;
        mCs  = 1'b0;
        mErr = 1'b0;
    endfunction

    // Advance the model by one clock edge using the inputs presented before it.
    function automatic void modelStep();
        bit             vp, vs, rdy, errNow;
        logic [NC-1:0]  dc;
        logic [NS-1:0]  pulse;
        int             tgt, hits, sel;
        bit             nBusy [NS];
        bit             nDone [NS];

        vp    = bus.disp_valid_parallel;
        vs    = bus.disp_valid_serial;
        dc    = bus.disp_core;
        rdy   = bus.commit_ready;
        pulse = {bus.serial_done, bus.core_done};
        errNow = 1'b0;
        tgt    = -1;

        if (vp && vs) begin
            errNow = 1'b1;
        end else if (vp) begin
            if ($countones(dc) != 1) begin
                errNow = 1'b1;
            end else begin
                for (int i = 0; i < NC; i++) if (dc[i]) tgt = i;
                if (mBusy[tgt]) begin
                    errNow = 1'b1;
                    tgt    = -1;
                end
            end
        end else if (vs) begin
            if (mBusy[NC]) errNow = 1'b1;
            else           tgt = NC;
        end

        nBusy = mBusy;
        nDone = mDone;
        for (int i = 0; i < NS; i++) begin
            if (pulse[i]) begin
                if (!mBusy[i]) errNow = 1'b1;
                else           nDone[i] = 1'b1;
            end
        end

        hits = 0;
        sel  = -1;
        for (int i = 0; i < NS; i++) begin
            if (mBusy[i] && mDone[i] && mId[i] == mExp) begin
                hits++;
                if (sel < 0) sel = i;
            end
        end
        if (hits > 1) errNow = 1'b1;

        if (sel >= 0 && (!mCv || rdy)) begin
            mCv        = 1'b1;
            mCid       = mId[sel];
            mCs        = (sel == NC);
            nBusy[sel] = 1'b0;
            nDone[sel] = 1'b0;
            mExp       = (mExp + 1) % ID_MOD;
        end else if (mCv && rdy) begin
            mCv = 1'b0;
        end

        if (tgt >= 0) begin
            nBusy[tgt] = 1'b1;
            nDone[tgt] = 1'b0;
            mId[tgt]   = int'(bus.disp_block_id);
        end

        mBusy = nBusy;
        mDone = nDone;
        mErr  = mErr | errNow;
    endfunction

    task automatic checkOutput();
        logic [NC-1:0] expMask;
        for (int i = 0; i < NC; i++) expMask[i] = !mBusy[i];
        checkVal("commit_valid",    bus.commit_valid,    mCv);
        checkVal("commit_block_id", bus.commit_block_id, mCid);
        checkVal("commit_serial",   bus.commit_serial,   mCs);
        checkVal("core_idle_mask",  bus.core_idle_mask,  expMask);
        checkVal("serial_idle",     bus.serial_idle,     !mBusy[NC]);
        checkVal("err",             bus.err,             mErr);
    endtask

    // Present one cycle of inputs, clock it, then compare against the model.
    task automatic applyStimulus(input bit vp, input bit vs, input logic [NC-1:0] dc,
                                 input logic [W-1:0] id, input logic [NC-1:0] cd,
                                 input bit sd, input bit rdy);
        bus.disp_valid_parallel = vp;
        bus.disp_valid_serial   = vs;
        bus.disp_core           = dc;
        bus.disp_block_id       = id;
        bus.core_done           = cd;
        bus.serial_done         = sd;
        bus.commit_ready        = rdy;
        if (bus.commit_valid === 1'b1 && rdy) begin
            checkVal("commit_order", bus.commit_block_id, acceptCount % ID_MOD);
            acceptCount++;
        end
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic idle(input bit rdy);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, rdy);
    endtask

    task automatic doReset();
        bus.disp_valid_parallel = 1'b0;
        bus.disp_valid_serial   = 1'b0;
        bus.disp_core           = '0;
        bus.disp_block_id       = '0;
        bus.core_done           = '0;
        bus.serial_done         = 1'b0;
        bus.commit_ready        = 1'b0;
        rst = 1'b0;
        modelReset();
        acceptCount = 0;
        #1;
        checkOutput();
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput();
    endtask

    // One randomized cycle of legal traffic with IDs handed out in order.
    task automatic randomStep();
        bit            vp = 1'b0, vs = 1'b0, sd = 1'b0, rdy;
        logic [NC-1:0] dc = '0, cd = '0;
        int            freeList [$];
        if ($urandom_range(0, 1) == 1) begin
            if ($urandom_range(0, 3) == 0) begin
                if (!mBusy[NC]) vs = 1'b1;
            end else begin
                for (int i = 0; i < NC; i++) if (!mBusy[i]) freeList.push_back(i);
                if (freeList.size() > 0) begin
                    vp = 1'b1;
                    dc[freeList[$urandom_range(0, freeList.size() - 1)]] = 1'b1;
                end
            end
        end
        for (int i = 0; i < NC; i++) if (mBusy[i] && $urandom_range(0, 2) == 0) cd[i] = 1'b1;
        if (mBusy[NC] && $urandom_range(0, 2) == 0) sd = 1'b1;
        rdy = ($urandom_range(0, 9) < 7);
        applyStimulus(vp, vs, dc, (vp || vs) ? W'(nextId) : W'($urandom), cd, sd, rdy);
        if (vp || vs) nextId++;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.disp_valid_parallel = 1'b0;
        bus.disp_valid_serial   = 1'b0;
        bus.disp_core           = '0;
        bus.disp_block_id       = '0;
        bus.core_done           = '0;
        bus.serial_done         = 1'b0;
        bus.commit_ready        = 1'b0;
        acceptCount = 0;
        nextId      = 0;
        modelReset();
        #2;

        // Basic: two parallel blocks finishing together retire back to back.
        $display("[TB] basic");
        doReset();
        checkVal("reset_idle_mask", bus.core_idle_mask, 4'b1111);
        applyStimulus(1, 0, 4'b0001, 8'd0, 4'b0000, 0, 1);
        applyStimulus(1, 0, 4'b0010, 8'd1, 4'b0000, 0, 1);
        checkVal("basic_busy_mask", bus.core_idle_mask, 4'b1100);
        applyStimulus(0, 0, 4'b0000, 8'd0, 4'b0011, 0, 1);
        checkVal("basic_no_commit_yet", bus.commit_valid, 1'b0);
        idle(1);
        checkVal("basic_first_valid", bus.commit_valid, 1'b1);
        checkVal("basic_first_id", bus.commit_block_id, 8'd0);
        checkVal("basic_core0_freed", bus.core_idle_mask, 4'b1101);
        idle(1);
        checkVal("basic_second_id", bus.commit_block_id, 8'd1);
        idle(1);
        checkVal("basic_all_idle", bus.core_idle_mask, 4'b1111);
        checkVal("basic_err", bus.err, 1'b0);

        // Reorder: a later parallel block waits behind an earlier serial one.
        $display("[TB] reorder");
        doReset();
        applyStimulus(0, 1, 4'b0000, 8'd0, 4'b0000, 0, 1);
        applyStimulus(1, 0, 4'b0100, 8'd1, 4'b0000, 0, 1);
        checkVal("reorder_serial_busy", bus.serial_idle, 1'b0);
        applyStimulus(0, 0, 4'b0000, 8'd0, 4'b0100, 0, 1);
        repeat (4) idle(1);
        checkVal("reorder_stalled", bus.commit_valid, 1'b0);
        checkVal("reorder_core2_busy", bus.core_idle_mask, 4'b1011);
        applyStimulus(0, 0, 4'b0000, 8'd0, 4'b0000, 1, 1);
        idle(1);
        checkVal("reorder_first_id", bus.commit_block_id, 8'd0);
        checkVal("reorder_first_serial", bus.commit_serial, 1'b1);
        checkVal("reorder_core2_still_busy", bus.core_idle_mask, 4'b1011);
        idle(1);
        checkVal("reorder_second_id", bus.commit_block_id, 8'd1);
        checkVal("reorder_second_serial", bus.commit_serial, 1'b0);
        checkVal("reorder_all_idle", bus.core_idle_mask, 4'b1111);
        idle(1);

        // Backpressure: the record holds while ready is low.
        $display("[TB] backpressure");
        doReset();
        applyStimulus(1, 0, 4'b0001, 8'd0, 4'b0000, 0, 0);
        applyStimulus(1, 0, 4'b0010, 8'd1, 4'b0000, 0, 0);
        applyStimulus(0, 0, 4'b0000, 8'd0, 4'b0011, 0, 0);
        for (int k = 0; k < 4; k++) begin
            idle(0);
            checkVal("bp_hold_valid", bus.commit_valid, 1'b1);
            checkVal("bp_hold_id", bus.commit_block_id, 8'd0);
            checkVal("bp_core1_busy", bus.core_idle_mask, 4'b1101);
        end
        idle(1);
        checkVal("bp_next_id", bus.commit_block_id, 8'd1);
        checkVal("bp_next_valid", bus.commit_valid, 1'b1);
        idle(1);
        checkVal("bp_drained", bus.commit_valid, 1'b0);

        // Errors: each illegal case on its own, slot state left untouched.
        $display("[TB] errors");
        doReset();
        applyStimulus(1, 0, 4'b0001, 8'd0, 4'b0000, 0, 1);
        applyStimulus(1, 0, 4'b0001, 8'd1, 4'b0000, 0, 1);
        checkVal("err_busy_core", bus.err, 1'b1);
        checkVal("err_busy_mask", bus.core_idle_mask, 4'b1110);
        idle(1);
        checkVal("err_sticky", bus.err, 1'b1);
        doReset();
        applyStimulus(1, 1, 4'b0001, 8'd0, 4'b0000, 0, 1);
        checkVal("err_both_valid", bus.err, 1'b1);
        checkVal("err_both_mask", bus.core_idle_mask, 4'b1111);
        checkVal("err_both_serial", bus.serial_idle, 1'b1);
        doReset();
        applyStimulus(0, 0, 4'b0000, 8'd0, 4'b0010, 0, 1);
        checkVal("err_done_idle", bus.err, 1'b1);
        doReset();
        applyStimulus(1, 0, 4'b0101, 8'd0, 4'b0000, 0, 1);
        checkVal("err_multi_hot", bus.err, 1'b1);
        checkVal("err_multi_mask", bus.core_idle_mask, 4'b1111);
        repeat (2) idle(1);

        // Same-edge freeing: dispatch into a slot on its load edge is refused.
        $display("[TB] same-edge freeing");
        doReset();
        applyStimulus(1, 0, 4'b0001, 8'd0, 4'b0000, 0, 1);
        applyStimulus(0, 0, 4'b0000, 8'd0, 4'b0001, 0, 1);
        applyStimulus(1, 0, 4'b0001, 8'd1, 4'b0000, 0, 1);
        checkVal("same_edge_err", bus.err, 1'b1);
        checkVal("same_edge_freed", bus.core_idle_mask, 4'b1111);
        applyStimulus(1, 0, 4'b0001, 8'd1, 4'b0000, 0, 1);
        checkVal("same_edge_redispatch", bus.core_idle_mask, 4'b1110);

        // Async reset in the middle of a burst.
        $display("[TB] async reset");
        doReset();
        applyStimulus(1, 0, 4'b0001, 8'd0, 4'b0000, 0, 0);
        applyStimulus(1, 0, 4'b0010, 8'd1, 4'b0000, 0, 0);
        applyStimulus(0, 1, 4'b0000, 8'd2, 4'b0011, 0, 0);
        idle(0);
        checkVal("async_pre_valid", bus.commit_valid, 1'b1);
        #3 rst = 1'b0;
        #1;
        checkVal("async_valid", bus.commit_valid, 1'b0);
        checkVal("async_id", bus.commit_block_id, 8'd0);
        checkVal("async_serial", bus.commit_serial, 1'b0);
        checkVal("async_mask", bus.core_idle_mask, 4'b1111);
        checkVal("async_serial_idle", bus.serial_idle, 1'b1);
        checkVal("async_err", bus.err, 1'b0);

        // Randomized legal traffic long enough to wrap the block ID space.
        $display("[TB] random");
        doReset();
        nextId = 0;
        for (int cyc = 0; cyc < 6000 && acceptCount < 300; cyc++) begin
            randomStep();
        end
        checkVal("random_wrap_reached", (acceptCount >= 300), 1'b1);
        repeat (20) begin
            randomStep();
        end
        for (int k = 0; k < 40; k++) begin
            applyStimulus(0, 0, '0, '0, ~bus.core_idle_mask & 4'b1111, ~bus.serial_idle, 1);
        end
        checkVal("random_drained_mask", bus.core_idle_mask, 4'b1111);
        checkVal("random_err", bus.err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
